line_buffer5: RTL
=================

Name: line_buffer5

Overview:
- Streaming 5-row line buffer that feeds the 5x5 convolution kernel stage.
- Accepts one pixel per `in_valid` in raster order (row-major, column 0 first).
- For each pixel of rows 4..map_height-1, emits five vertically aligned pixels: rows r-4..r, same column.
- Outputs connect directly to the convolution kernel's `d_in1..d_in5` / `in_valid`.

Parameters:
- data_width, 16, pixel width in bits.
- map_width, 28, pixels per row; must be >= 5.
- map_height, 28, rows per frame; must be >= 5.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous frame restart; discards buffered history.
- d_in  input  data_width  input pixel.
- in_valid  input  1  d_in valid this cycle; no backpressure.
- d_out1  output  data_width  pixel from row r-4 (oldest).
- d_out2  output  data_width  pixel from row r-3.
- d_out3  output  data_width  pixel from row r-2.
- d_out4  output  data_width  pixel from row r-1.
- d_out5  output  data_width  pixel from row r (current input, registered).
- out_valid  output  1  d_out1..d_out5 form a valid column this cycle.
- frame_done  output  1  one-cycle pulse with the last column output of a frame.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - col_cnt=0, row_cnt=0, ring pointer=0.
  - All d_out*=0, out_valid=0, frame_done=0.
  - Row memory contents are not cleared; they are unobservable because out_valid is gated by row_cnt.
- Storage:
  - Four row memories, each map_width x data_width, organised as a ring indexed by a 2-bit pointer `wp`.
  - Memory wp holds the oldest row (r-4); wp+1, wp+2, wp+3 hold rows r-3, r-2, r-1.
  - Every memory is addressed by col_cnt with read-before-write.
- Pixel accept (in_valid=1, clear=0):
  - Read all four memories at col_cnt.
  - Write d_in into memory wp at col_cnt, overwriting row r-4 with row r.
  - Register the outputs: d_out1=mem[wp], d_out2=mem[wp+1], d_out3=mem[wp+2], d_out4=mem[wp+3], d_out5=d_in.
- Latency: exactly 1 cycle from the accepting edge to out_valid/data.
- out_valid = 1 the cycle after an accept iff the accepted row_cnt >= 4. Otherwise 0.
- Output hold: d_out* hold their last values when out_valid=0. Consumers must ignore them.
- Counters, applied on each accept:
  - col_cnt increments; at map_width-1 it wraps to 0 and row_cnt increments.
  - On that same wrap, wp = wp+1 mod 4.
  - At col_cnt=map_width-1 and row_cnt=map_height-1, row_cnt wraps to 0. The next frame starts with no valid history.
- frame_done: 1 the cycle after accepting the pixel at (map_height-1, map_width-1), coincident with its out_valid. Otherwise 0.
- Gaps: in_valid=0 cycles freeze all counters and the pointer. out_valid=0 and frame_done=0 the following cycle.
- Throughput: back-to-back frames at 1 pixel/cycle are supported without bubbles.
- Row output count: each frame yields (map_height-4)*map_width out_valid cycles. The downstream stage derives column position from its own counter.
- clear=1:
  - Takes priority over in_valid; a pixel presented with clear is discarded.
  - col_cnt, row_cnt, wp <- 0; out_valid=0 and frame_done=0 next cycle.
- Reset mid-frame behaves identically to clear, and additionally zeroes d_out*.
- Widths:
  - col_cnt is $clog2(map_width) bits; row_cnt is $clog2(map_height) bits.
  - No arithmetic on data; pixels pass bit-exact.

Decomposition:
- Shared package `cnn_pkg`: constant KERNEL_SIZE=5 and derived LINE_ROWS=KERNEL_SIZE-1. The ring width derives from LINE_ROWS.
- One sub-module `row_mem`:
  - Parameterised by data_width and depth.
  - Single-port, synchronous write, combinational read, read-before-write semantics.
  - Instantiated LINE_ROWS times.
- Counter, pointer and output registers stay in line_buffer5.

Test Plan:
- Single frame: 28x28 ramp, pixel=row*28+col, continuous in_valid.
  - First out_valid 1 cycle after accepting pixel 112, with d_out1..5 = 0, 28, 56, 84, 112.
  - 672 out_valid cycles in total; frame_done on the last, with d_out5=783 and d_out1=671.
- Random gaps: same ramp with in_valid pseudo-random (~50%) -> identical output sequence, no out_valid during gap-following cycles.
- Back-to-back frames: two ramp frames, second offset +1000 per pixel.
  - No out_valid for frame-2 rows 0..3.
  - Frame-2 first output d_out1=1000, d_out5=1112; exactly 1344 valids in total.
- Clear mid-frame: assert clear together with the pixel at row 10, col 5 (value 285), then restart the ramp.
  - That pixel is dropped, with no valid on the next cycle.
  - First post-clear output d_out1=0, d_out5=112; no stale rows appear.
- Reset mid-frame: rst_n=0 for 2 cycles at row 6, then a fresh ramp.
  - All outputs are 0 during and after reset until the first valid.
  - Sequence matches the single-frame scenario.
- Minimum size: map_width=5, map_height=5 with a ramp -> exactly 5 valids, d_out1=0..4, d_out5=20..24, frame_done on the fifth.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the convolution pipeline: kernel geometry and the
// line-buffer ring pointer type derived from it.
package cnn_pkg;

  localparam int KERNEL_SIZE = 5;
  localparam int LINE_ROWS   = KERNEL_SIZE - 1;
  localparam int PTR_W       = $clog2(LINE_ROWS);

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/row_mem.sv
// Single-port row memory: synchronous write, combinational read, so a read and
// write to the same address in one cycle returns the old contents.
module row_mem #(
  parameter int data_width = 16,
  parameter int depth      = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [data_width-1:0]    wdata,
  output logic [data_width-1:0]    rdata
);

  logic [data_width-1:0] mem [depth];

  // NOTE: storage arrays carry no reset; validity is tracked by the counters
  // that own them, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer5.sv
// Streaming 5-row line buffer: four row memories in a ring plus the live input
// produce one vertically aligned 5-pixel column per accepted pixel of rows 4+.
module line_buffer5
  import cnn_pkg::*;
#(
  parameter int data_width = 16,
  parameter int map_width  = 28,
  parameter int map_height = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [data_width-1:0] d_in,
  input  logic                  in_valid,
  output logic [data_width-1:0] d_out1,
  output logic [data_width-1:0] d_out2,
  output logic [data_width-1:0] d_out3,
  output logic [data_width-1:0] d_out4,
  output logic [data_width-1:0] d_out5,
  output logic                  out_valid,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(map_width);
  localparam int ROW_W = $clog2(map_height);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(map_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(map_height - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(LINE_ROWS);

  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  ptr_t                  wp;
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  produce;
  logic [data_width-1:0] rd   [LINE_ROWS];
  logic [data_width-1:0] tap  [LINE_ROWS];
  logic [data_width-1:0] dout [KERNEL_SIZE];

  assign accept   = in_valid && !clear;
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);
  assign produce  = accept && (row_cnt >= ROW_FIRST);

  // Only the memory holding the oldest row is written; it is replaced by row r.
  for (genvar i = 0; i < LINE_ROWS; i++) begin : g_mem
    row_mem #(
      .data_width(data_width),
      .depth     (map_width)
    ) u_row_mem (
      .clk  (clk),
      .we   (accept && (wp == ptr_t'(i))),
      .addr (col_cnt),
      .wdata(d_in),
      .rdata(rd[i])
    );
  end

  // Rotate the ring so tap[0] is always the oldest row.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tap = '{default: '0};
    for (int k = 0; k < LINE_ROWS; k++) begin
      tap[k] = rd[wp + ptr_t'(k)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
      wp      <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        wp      <= wp + ptr_t'(1);
        row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  // Data registers load only for valid columns; otherwise they hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '{default: '0};
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= produce;
      frame_done <= accept && col_last && row_last;
      if (produce) begin
        for (int k = 0; k < LINE_ROWS; k++) dout[k] <= tap[k];
        dout[LINE_ROWS] <= d_in;
      end
    end
  end

  assign d_out1 = dout[0];
  assign d_out2 = dout[1];
  assign d_out3 = dout[2];
  assign d_out4 = dout[3];
  assign d_out5 = dout[4];

endmodule
